// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the memory-vector sequencer.
//   - Array geometry: NUM_ROWS wordlines, ROW_W row-index bits,
//     COL_W column-address bits, DATA_W element bits.
//   - Command opcodes carried on cmd_op.
//   - Sequencer FSM state type.
package mem_ctrl_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned COL_W    = 8;
    localparam int unsigned DATA_W   = 8;

    localparam logic [1:0] OP_LOAD    = 2'd0;
    localparam logic [1:0] OP_READOUT = 2'd1;
    localparam logic [1:0] OP_ADD     = 2'd2;
    localparam logic [1:0] OP_CLEAR   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RD,
        ST_RD_HOLD,
        ST_ADD_RD,
        ST_ADD_WR,
        ST_CLR,
        ST_DONE
    } state_e;

endpackage

// File: rtl/mem_vector_ctrl_row_onehot.sv
// row_onehot: combinational row-index to one-hot wordline decoder.
//   idx_i    [ROW_W-1:0]    row index
//   onehot_o [NUM_ROWS-1:0] single bit set at position idx_i
module row_onehot
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROWS = mem_ctrl_pkg::NUM_ROWS,
    parameter int unsigned ROW_W    = mem_ctrl_pkg::ROW_W
) (
    input  logic [ROW_W-1:0]    idx_i,
    output logic [NUM_ROWS-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/mem_vector_ctrl.sv
// mem_vector_ctrl: command sequencer for the 8-row x 256-column
// compute-in-memory vector array. Runs one command at a time
// (LOAD, READOUT, ADD, CLEAR) and drives the array control strobes.
//   clk, rst                  clock, async active-high reset
//   cmd_*                     command port (valid/ready), latched on accept
//   wr_data/wr_valid/wr_ready LOAD element stream (data goes to the array
//                             data-in directly; the controller only paces it)
//   rd_data/rd_valid/rd_ready READOUT element stream
//   done                      one-cycle pulse at command completion
//   mem_*                     registered array controls; mem_dout is the
//                             array's combinational data-out
module mem_vector_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROWS = mem_ctrl_pkg::NUM_ROWS,
    parameter int unsigned ROW_W    = mem_ctrl_pkg::ROW_W,
    parameter int unsigned COL_W    = mem_ctrl_pkg::COL_W,
    parameter int unsigned DATA_W   = mem_ctrl_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ROW_W-1:0]    cmd_src_a,
    input  logic [ROW_W-1:0]    cmd_src_b,
    input  logic [ROW_W-1:0]    cmd_dst,
    input  logic [COL_W-1:0]    cmd_col,
    input  logic [COL_W:0]      cmd_len,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                done,
    output logic                mem_en,
    output logic [NUM_ROWS-1:0] mem_rwl,
    output logic [NUM_ROWS-1:0] mem_wwl,
    output logic [COL_W-1:0]    mem_col,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_clr,
    input  logic [DATA_W-1:0]   mem_dout
);

    localparam logic [COL_W:0]   LEN_FULL = {1'b1, {COL_W{1'b0}}};
    localparam logic [COL_W:0]   LEN_ONE  = {{COL_W{1'b0}}, 1'b1};
    localparam logic [COL_W-1:0] COL_ONE  = {{(COL_W-1){1'b0}}, 1'b1};

    state_e              state_q;
    logic                cmd_ready_q, wr_ready_q, rd_valid_q, done_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                mem_en_q, mem_read_q, mem_write_q, mem_clr_q;
    logic [NUM_ROWS-1:0] mem_rwl_q, mem_wwl_q;
    logic [COL_W-1:0]    mem_col_q, col_ptr_q;
    logic [COL_W:0]      remaining_q;
    logic [ROW_W-1:0]    src_a_q, src_b_q, dst_q;
    logic [ROW_W-1:0]    src_a_d, src_b_d, dst_d;
    logic [NUM_ROWS-1:0] oh_a, oh_b, oh_dst;
    logic                accept;
    logic                unused_wr_data;

    assign unused_wr_data = ^wr_data;

    assign accept = cmd_valid & cmd_ready_q;

    // Row indices bypass their registers on the accept cycle so the first
    // wordline pattern can be registered together with the state change.
    assign src_a_d = accept ? cmd_src_a : src_a_q;
    assign src_b_d = accept ? cmd_src_b : src_b_q;
    assign dst_d   = accept ? cmd_dst   : dst_q;

    row_onehot #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W)) u_oh_a   (.idx_i(src_a_d), .onehot_o(oh_a));
    row_onehot #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W)) u_oh_b   (.idx_i(src_b_d), .onehot_o(oh_b));
    row_onehot #(.NUM_ROWS(NUM_ROWS), .ROW_W(ROW_W)) u_oh_dst (.idx_i(dst_d),   .onehot_o(oh_dst));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_clr_q   <= 1'b0;
            mem_rwl_q   <= '0;
            mem_wwl_q   <= '0;
            mem_col_q   <= '0;
            col_ptr_q   <= '0;
            remaining_q <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
        end else begin
            src_a_q <= src_a_d;
            src_b_q <= src_b_d;
            dst_q   <= dst_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        col_ptr_q   <= cmd_col;
                        remaining_q <= (cmd_len == '0) ? LEN_FULL : cmd_len;
                        case (cmd_op)
                            OP_LOAD: begin
                                state_q    <= ST_LOAD;
                                wr_ready_q <= 1'b1;
                            end
                            OP_READOUT: begin
                                state_q    <= ST_RD;
                                mem_en_q   <= 1'b1;
                                mem_read_q <= 1'b1;
                                mem_rwl_q  <= oh_a;
                                mem_col_q  <= cmd_col;
                            end
                            OP_ADD: begin
                                state_q    <= ST_ADD_RD;
                                mem_en_q   <= 1'b1;
                                mem_read_q <= 1'b1;
                                mem_rwl_q  <= oh_a | oh_b;
                                mem_col_q  <= cmd_col;
                            end
                            default: begin
                                state_q   <= ST_CLR;
                                mem_clr_q <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (wr_valid) begin
                        mem_en_q    <= 1'b1;
                        mem_write_q <= 1'b1;
                        mem_wwl_q   <= oh_dst;
                        mem_col_q   <= col_ptr_q;
                        col_ptr_q   <= col_ptr_q + COL_ONE;
                        remaining_q <= remaining_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) begin
                            wr_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end
                    end else begin
                        mem_en_q    <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_wwl_q   <= '0;
                    end
                end
                ST_RD: begin
                    rd_data_q   <= mem_dout;
                    rd_valid_q  <= 1'b1;
                    mem_en_q    <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_rwl_q   <= '0;
                    col_ptr_q   <= col_ptr_q + COL_ONE;
                    remaining_q <= remaining_q - LEN_ONE;
                    state_q     <= ST_RD_HOLD;
                end
                ST_RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid_q <= 1'b0;
                        if (remaining_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            mem_en_q   <= 1'b1;
                            mem_read_q <= 1'b1;
                            mem_rwl_q  <= oh_a;
                            mem_col_q  <= col_ptr_q;
                            state_q    <= ST_RD;
                        end
                    end
                end
                ST_ADD_RD: begin
                    mem_read_q  <= 1'b0;
                    mem_rwl_q   <= '0;
                    mem_write_q <= 1'b1;
                    mem_wwl_q   <= oh_dst;
                    state_q     <= ST_ADD_WR;
                end
                ST_ADD_WR: begin
                    mem_write_q <= 1'b0;
                    mem_wwl_q   <= '0;
                    col_ptr_q   <= col_ptr_q + COL_ONE;
                    remaining_q <= remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        mem_en_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        mem_read_q <= 1'b1;
                        mem_rwl_q  <= oh_a | oh_b;
                        mem_col_q  <= col_ptr_q + COL_ONE;
                        state_q    <= ST_ADD_RD;
                    end
                end
                ST_CLR: begin
                    mem_clr_q <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= ST_DONE;
                end
                ST_DONE: begin
                    // LOAD reaches here with its final write still on the bus.
                    done_q      <= 1'b0;
                    mem_en_q    <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_wwl_q   <= '0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign mem_en    = mem_en_q;
    assign mem_rwl   = mem_rwl_q;
    assign mem_wwl   = mem_wwl_q;
    assign mem_col   = mem_col_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_clr   = mem_clr_q;

endmodule

// File: doc/mem_vector_ctrl.md
Name: mem_vector_ctrl

Overview:
- Sequencer for the 8-row x 256-column compute-in-memory vector array.
- Accepts one command at a time over a valid/ready port and drives the array controls: enable, read/write wordlines, column address, READ, Write, Clr.
- Supports four operations: row load, row readout, in-array two-row add with write-back, and output clear.
- Sits between the engine's top-level scheduler and the memory vector.

Parameters:
- NUM_ROWS, 8, number of wordlines (one-hot RWL/WWL width).
- ROW_W, 3, row index width (log2 NUM_ROWS).
- COL_W, 8, column address width (256 columns).
- DATA_W, 8, vector element width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle, command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  0=LOAD, 1=READOUT, 2=ADD, 3=CLEAR.
- cmd_src_a  in  ROW_W  first source row (READOUT, ADD).
- cmd_src_b  in  ROW_W  second source row (ADD).
- cmd_dst  in  ROW_W  destination row (LOAD, ADD).
- cmd_col  in  COL_W  start column.
- cmd_len  in  COL_W+1  column count; 0 means 256.
- wr_data  in  DATA_W  LOAD element.
- wr_valid  in  1  LOAD element valid.
- wr_ready  out  1  LOAD element consumed.
- rd_data  out  DATA_W  READOUT element.
- rd_valid  out  1  READOUT element valid.
- rd_ready  in  1  READOUT sink ready.
- done  out  1  one-cycle pulse at command completion.
- mem_en  out  1  array row-decoder enable.
- mem_rwl  out  NUM_ROWS  read wordlines.
- mem_wwl  out  NUM_ROWS  write wordlines.
- mem_col  out  COL_W  column address.
- mem_read  out  1  array READ.
- mem_write  out  1  array Write.
- mem_clr  out  1  array Clr.
- mem_dout  in  DATA_W  array DataOut (combinational from registered controls).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all mem_* outputs are 0, wr_ready, rd_valid, done and rd_data are 0, state is IDLE.
- All outputs are registered. cmd_ready = (state==IDLE), so it reads 1 during and after reset.
- Command capture: op, rows, col and len are latched on acceptance. col_ptr = cmd_col and remaining = len (0 becomes 256).
- Column pointer: mem_col = col_ptr, which increments modulo 256 per column; start+len > 256 wraps to column 0.
- States: IDLE, LOAD, RD, RD_HOLD, ADD_RD, ADD_WR, CLR, DONE.
- IDLE -> LOAD / RD / ADD_RD / CLR on acceptance, according to op.
- LOAD:
  - wr_ready=1.
  - On each wr_valid cycle: mem_write=1, mem_wwl=onehot(dst), mem_en=1 for that column; then col_ptr++ and remaining--.
  - If wr_valid=0, no write that cycle and the FSM stays in LOAD.
  - After the last column -> DONE. N columns take N cycles at full rate.
- RD:
  - mem_read=1, mem_rwl=onehot(src_a), mem_en=1 for one cycle.
  - mem_dout is captured into rd_data at the ending edge and rd_valid is set -> RD_HOLD.
- RD_HOLD:
  - Array controls deasserted.
  - Hold rd_data/rd_valid until rd_ready; then clear rd_valid and go to RD (next column) or DONE.
  - Minimum 2 cycles per column.
- ADD_RD:
  - mem_read=1, mem_rwl = onehot(src_a) | onehot(src_b), mem_en=1 -> ADD_WR.
  - src_a==src_b yields a single-hot RWL.
- ADD_WR:
  - mem_write=1, mem_wwl=onehot(dst), mem_en=1, same column.
  - Then the next column goes to ADD_RD, or the FSM goes to DONE. Cost is 2N cycles.
  - dst may equal either source, because the read always precedes the write.
- CLR: mem_clr=1 for exactly one cycle -> DONE. len and col are ignored.
- DONE: done=1 for one cycle -> IDLE. cmd_ready is 0 here, so back-to-back commands have a 1-cycle gap.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_rwl and mem_wwl are all-zero whenever their strobe is 0.
  - mem_clr is exclusive with both mem_read and mem_write.
- Reset mid-operation: immediate return to IDLE with all outputs 0, no done pulse, and any partial command is abandoned.
- cmd_valid while busy is ignored (not queued).

Decomposition:
- Package mem_ctrl_pkg holds:
  - Opcode localparams OP_LOAD, OP_READOUT, OP_ADD, OP_CLEAR.
  - FSM state encodings.
  - Width constants ROW_W, COL_W, DATA_W.
- One sub-module, row_onehot: ROW_W-bit index to NUM_ROWS one-hot, combinational. It is instantiated for src_a, src_b and dst.

Test Plan:
- LOAD dst=3, col=250, len=10, wr_valid constant, data 0x10..0x19 -> mem_wwl=0x08 with mem_col 250..255,0..3; 10 write cycles, then done.
- READOUT src_a=3, col=250, len=10, mem_dout model returns stored data, rd_ready toggling 1/0 -> rd_data 0x10..0x19 in order, each held until accepted, no drops.
- ADD src_a=1, src_b=2, dst=1, col=0, len=0 -> 256 alternating read/write pairs (mem_rwl=0x06 then mem_wwl=0x02); 512 cycles, then a single done pulse.
- CLEAR -> mem_clr high for exactly 1 cycle, done on the next cycle, cmd_ready back after DONE.
- LOAD len=4 with wr_valid gaps (1,0,0,1,1,0,1) -> exactly 4 writes, and mem_col advances only on valid.
- Assert rst during ADD_WR of column 5 -> all mem_* go to 0 asynchronously, no done pulse, cmd_ready=1; a new LOAD is accepted after reset release.
